// File: rtl/peridot_st_pkg.sv
// Shared protocol constants and decoder state type for the byte-stuffed
// Avalon-ST packet link (bytes-to-packets and packets-to-bytes sides).
package peridot_st_pkg;

    localparam logic [7:0] ST_SOP_CHAR  = 8'h7A;
    localparam logic [7:0] ST_EOP_CHAR  = 8'h7B;
    localparam logic [7:0] ST_CHAN_CHAR = 8'h7C;
    localparam logic [7:0] ST_ESC_CHAR  = 8'h7D;
    localparam logic [7:0] ST_ESC_XOR   = 8'h20;

    typedef enum logic [1:0] {
        DATA     = 2'd0,
        ESC      = 2'd1,
        CHAN     = 2'd2,
        CHAN_ESC = 2'd3
    } b2p_state_t;

endpackage

// File: rtl/peridot_st_bytes_to_packets.sv
// Byte-stuffed stream decoder: UART byte stream in, Avalon-ST packets out.
// Channel decode is built only when PERIDOT_ST_B2P_CHANNEL_EN is defined.
module peridot_st_bytes_to_packets #(
    parameter int CHANNEL_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     in_ready,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_error,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [7:0]               out_data,
    output logic                     out_startofpacket,
    output logic                     out_endofpacket,
    output logic [CHANNEL_WIDTH-1:0] out_channel,
    output logic                     out_error
);
    import peridot_st_pkg::*;

    b2p_state_t state_q, state_d;
    logic       sop_pend_q, sop_pend_d;
    logic       eop_pend_q, eop_pend_d;
    logic       err_pend_q, err_pend_d;
    logic       out_valid_q, out_valid_d;
    logic [7:0] out_data_q, out_data_d;
    logic       out_sop_q, out_sop_d;
    logic       out_eop_q, out_eop_d;
    logic       out_err_q, out_err_d;
    logic       accept;
    logic       emit;
    logic [7:0] payload;

`ifdef PERIDOT_ST_B2P_CHANNEL_EN
    logic [CHANNEL_WIDTH-1:0] chan_q, chan_d;
    logic [CHANNEL_WIDTH-1:0] out_chan_q, out_chan_d;

    // Zero-extend before slicing so any CHANNEL_WIDTH keeps the byte's LSBs.
    function automatic logic [CHANNEL_WIDTH-1:0] to_chan(input logic [7:0] b);
        logic [CHANNEL_WIDTH+7:0] ext;
        ext = {{CHANNEL_WIDTH{1'b0}}, b};
        return ext[CHANNEL_WIDTH-1:0];
    endfunction
`endif

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        sop_pend_d  = sop_pend_q;
        eop_pend_d  = eop_pend_q;
        err_pend_d  = err_pend_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_err_d   = out_err_q;
        emit        = 1'b0;
        payload     = 8'h00;
`ifdef PERIDOT_ST_B2P_CHANNEL_EN
        chan_d      = chan_q;
        out_chan_d  = out_chan_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_error) begin
                err_pend_d = 1'b1;
            end
            case (state_q)
                DATA: begin
                    if (in_data == ST_SOP_CHAR)       sop_pend_d = 1'b1;
                    else if (in_data == ST_EOP_CHAR)  eop_pend_d = 1'b1;
                    else if (in_data == ST_CHAN_CHAR) state_d = CHAN;
                    else if (in_data == ST_ESC_CHAR)  state_d = ESC;
                    else begin
                        emit    = 1'b1;
                        payload = in_data;
                    end
                end
                ESC: begin
                    emit    = 1'b1;
                    payload = in_data ^ ST_ESC_XOR;
                    state_d = DATA;
                end
                CHAN: begin
                    // Framing marks win over a channel value; channel is kept.
                    if (in_data == ST_ESC_CHAR) begin
                        state_d = CHAN_ESC;
                    end else if (in_data == ST_SOP_CHAR) begin
                        sop_pend_d = 1'b1;
                        state_d    = DATA;
                    end else if (in_data == ST_EOP_CHAR) begin
                        eop_pend_d = 1'b1;
                        state_d    = DATA;
                    end else if (in_data == ST_CHAN_CHAR) begin
                        state_d = CHAN;
                    end else begin
`ifdef PERIDOT_ST_B2P_CHANNEL_EN
                        chan_d = to_chan(in_data);
`endif
                        state_d = DATA;
                    end
                end
                CHAN_ESC: begin
`ifdef PERIDOT_ST_B2P_CHANNEL_EN
                    chan_d = to_chan(in_data ^ ST_ESC_XOR);
`endif
                    state_d = DATA;
                end
                default: state_d = DATA;
            endcase
        end

        // An error on the payload byte itself belongs to that byte.
        if (emit) begin
            out_valid_d = 1'b1;
            out_data_d  = payload;
            out_sop_d   = sop_pend_q;
            out_eop_d   = eop_pend_q;
            out_err_d   = err_pend_q || in_error;
            sop_pend_d  = 1'b0;
            eop_pend_d  = 1'b0;
            err_pend_d  = 1'b0;
`ifdef PERIDOT_ST_B2P_CHANNEL_EN
            out_chan_d  = chan_q;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= DATA;
            sop_pend_q  <= 1'b0;
            eop_pend_q  <= 1'b0;
            err_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sop_pend_q  <= sop_pend_d;
            eop_pend_q  <= eop_pend_d;
            err_pend_q  <= err_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_err_q   <= out_err_d;
        end
    end

`ifdef PERIDOT_ST_B2P_CHANNEL_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chan_q     <= '0;
            out_chan_q <= '0;
        end else begin
            chan_q     <= chan_d;
            out_chan_q <= out_chan_d;
        end
    end

    assign out_channel = out_chan_q;
`else
    assign out_channel = '0;
`endif

    assign out_valid         = out_valid_q;
    assign out_data          = out_data_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_error         = out_err_q;

endmodule

// File: doc/peridot_st_bytes_to_packets.md
Name: peridot_st_bytes_to_packets

Overview:
Downstream consumer of the UART receiver phy's 8-bit Avalon-ST byte stream (valid/ready/data/error[0]=overflow). Decodes the byte-stuffed packet protocol and emits an Avalon-ST packet stream with SOP, EOP and channel. Protocol characters:
- 0x7A SOP mark
- 0x7B EOP mark
- 0x7C channel mark
- 0x7D escape: the next byte is XORed with 0x20

Feeds the host-bridge packet layer.

Parameters:
- CHANNEL_WIDTH, 8, width of out_channel; the received channel byte is truncated to its LSBs.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- in_valid  in  1  byte stream valid.
- in_data  in  8  received byte.
- in_error  in  1  [0] overflow flag from the phy, qualified by in_valid.
- out_ready  in  1  sink ready.
- out_valid  out  1  packet data valid.
- out_data  out  8  decoded payload byte.
- out_startofpacket  out  1  first byte of packet.
- out_endofpacket  out  1  last byte of packet.
- out_channel  out  CHANNEL_WIDTH  channel of current byte.
- out_error  out  1  [0] upstream overflow occurred since the previous emitted byte.

Behaviour:
- Reset values: out_valid=0, out_data=0x00, out_startofpacket=0, out_endofpacket=0, out_channel=0, out_error=0. Internal state is DATA, all pending flags are 0, and the channel register is 0.
- Single output register stage. in_ready = !out_valid || out_ready (combinational). No data is lost or duplicated under back-pressure.
- Latency: a payload byte accepted in cycle N appears on out_* with out_valid=1 in cycle N+1.
- Non-payload bytes (marks, escape, channel byte) are consumed with in_ready=1 and produce no output; they do not disturb a held output.
- out_valid clears on the handshake (out_valid && out_ready) unless a new payload is loaded in the same cycle.
- State machine on each accepted byte b. Decode priority within a state follows the order listed.
  - DATA:
    - 0x7A sets sop_pend.
    - 0x7B sets eop_pend.
    - 0x7C goes to CHAN.
    - 0x7D goes to ESC.
    - Any other byte is emitted as payload.
  - ESC: emit b^0x20 as payload; go to DATA.
  - CHAN:
    - 0x7D goes to CHAN_ESC.
    - 0x7A/0x7B/0x7C are treated as in DATA; channel is unchanged.
    - Any other byte: channel <= b; go to DATA.
  - CHAN_ESC: channel <= b^0x20; go to DATA.
- Payload emit:
  - out_startofpacket = sop_pend, out_endofpacket = eop_pend, out_channel = current channel, out_error = err_pend.
  - sop_pend, eop_pend and err_pend all clear on the emit.
  - SOP and EOP both pending means a single-byte packet with both set.
- A repeated SOP or EOP mark before payload is idempotent (still one flag).
- err_pend is set by any accepted byte with in_error=1, including non-payload bytes. It is sticky until the next emitted payload byte.
- The channel register persists across packets until a new channel byte arrives.
- No packet-framing checking: SOP without a prior EOP is passed through unchanged.
- Reset mid-packet: all state and pending flags are discarded; decoding restarts in DATA.

Optional Feature:
Macro: PERIDOT_ST_B2P_CHANNEL_EN
- Defined: channel decode as described above.
- Undefined:
  - out_channel is tied to 0.
  - 0x7C and its following byte (plus an escape, if present) are consumed and discarded, walking the CHAN/CHAN_ESC states without storing.
  - The channel register is not synthesised.

Decomposition:
- Shared package peridot_st_pkg holds:
  - constants ST_SOP_CHAR=8'h7A, ST_EOP_CHAR=8'h7B, ST_CHAN_CHAR=8'h7C, ST_ESC_CHAR=8'h7D, ST_ESC_XOR=8'h20;
  - the state enum type b2p_state_t {DATA, ESC, CHAN, CHAN_ESC}.
- The packets-to-bytes transmit side reuses the same package.
- No sub-module: the decoder and output register stay in one file.

Test Plan:
- Single-byte packet: in 7A 7B 41 -> one output 0x41 with sop=1, eop=1, channel=0, error=0.
- Escaped payload and channel: in 7C 7D 5C 7A 7D 5A 55 7B 7D 5D, with PERIDOT_ST_B2P_CHANNEL_EN defined, ->
  - 0x7A with sop=1, channel=0x7C;
  - 0x55 with no flags;
  - 0x7D with eop=1.
- Back-pressure: 3-byte packet 7A 01 02 7B 03 with out_ready held 0 for 5 cycles, then 1 -> in_ready=0 while the output is held; outputs 01(sop), 02, 03(eop) in order with no loss.
- Overflow propagation: in_error=1 on the byte 0x7A ahead of 0x10, then 0x11 clean -> 0x10 with error=1 and sop=1; 0x11 with error=0.
- Reset mid-operation: assert reset after 7A 7D -> all outputs 0; the next input 0x5A emits 0x5A (not 0x7A) with sop=0.
- Macro undefined: 7C 05 33 -> one output 0x33 with channel=0.
